// File: rtl/output_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_lock_arbiter
// Description : Per-output round-robin arbiter with packet locking and credit
//               flow control. Define OUTPUT_LOCK_CREDIT_CHECK_EN to enable the
//               sticky credit-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef N
`define N 4
`endif
`ifndef M
`define M 4
`endif

module output_lock_arbiter #(
    parameter int N       = `N,
    parameter int M       = `M,
    parameter int CREDITS = 4,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic [0:N-1]            i_valid,
    input  logic [0:N-1]            i_tail,
    input  logic [0:N-1][0:M-1]     i_output_req,
    input  logic [0:M-1]            i_credit_return,
    output logic [0:M-1][0:N-1]     o_output_grant,
    output logic [0:N-1]            o_input_grant,
    output logic [0:M-1]            o_locked,
    output logic [0:M-1][CW-1:0]    o_credit_count,
    output logic [0:M-1]            o_credit_err
);

    localparam int         IW          = (N > 1) ? $clog2(N) : 1;
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    // Rows requesting more than one output are not valid requests.
    logic [0:N-1] w_req_ok;

    always_comb begin
        w_req_ok = '0;
        for (int n = 0; n < N; n++) begin
            w_req_ok[n] = i_valid[n] && $onehot(i_output_req[n]);
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_out
        logic [0:0]    r_state;
        logic [0:0]    w_state_nxt;
        logic [IW-1:0] r_owner;
        logic [IW-1:0] w_owner_nxt;
        logic [IW-1:0] r_ptr;
        logic [IW-1:0] w_ptr_nxt;
        logic [CW-1:0] r_credit;
        logic [CW-1:0] w_credit_nxt;
        logic [IW-1:0] w_sel;
        logic [0:N-1]  w_req;
        logic [0:N-1]  w_gnt;
        logic          w_found;
        logic          w_any;

        always_comb begin
            w_req        = '0;
            w_gnt        = '0;
            w_sel        = '0;
            w_found      = 1'b0;
            w_any        = 1'b0;
            w_state_nxt  = r_state;
            w_owner_nxt  = r_owner;
            w_ptr_nxt    = r_ptr;
            w_credit_nxt = r_credit;

            for (int n = 0; n < N; n++) begin
                w_req[n] = w_req_ok[n] && i_output_req[n][m];
            end

            if (r_state == c_ST_LOCKED) begin
                w_sel   = r_owner;
                w_found = w_req[r_owner];
            end else begin
                for (int off = 0; off < N; off++) begin
                    if (!w_found && w_req[IW'((int'(r_ptr) + off) % N)]) begin
                        w_found = 1'b1;
                        w_sel   = IW'((int'(r_ptr) + off) % N);
                    end
                end
            end

            w_any = ce && (r_credit != '0) && w_found;
            if (w_any) begin
                w_gnt[w_sel] = 1'b1;
            end

            if (ce) begin
                if (w_any) begin
                    if (r_state == c_ST_LOCKED) begin
                        if (i_tail[w_sel]) begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end else begin
                        if (!i_tail[w_sel]) begin
                            w_state_nxt = c_ST_LOCKED;
                            w_owner_nxt = w_sel;
                        end
                        w_ptr_nxt = (w_sel == IW'(N - 1)) ? '0 : w_sel + 1'b1;
                    end
                end
                // Simultaneous grant and return cancel out.
                if (w_any && !i_credit_return[m]) begin
                    w_credit_nxt = r_credit - 1'b1;
                end else if (!w_any && i_credit_return[m] && (r_credit != CW'(CREDITS))) begin
                    w_credit_nxt = r_credit + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state  <= c_ST_IDLE;
                r_owner  <= '0;
                r_ptr    <= '0;
                r_credit <= CW'(CREDITS);
            end else begin
                r_state  <= w_state_nxt;
                r_owner  <= w_owner_nxt;
                r_ptr    <= w_ptr_nxt;
                r_credit <= w_credit_nxt;
            end
        end

        assign o_output_grant[m] = w_gnt;
        assign o_locked[m]       = (r_state == c_ST_LOCKED);
        assign o_credit_count[m] = r_credit;

`ifdef OUTPUT_LOCK_CREDIT_CHECK_EN
        logic r_err;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_err <= 1'b0;
            end else if (ce && i_credit_return[m] && !w_any && (r_credit == CW'(CREDITS))) begin
                r_err <= 1'b1;
            end
        end

        assign o_credit_err[m] = r_err;
`else
        assign o_credit_err[m] = 1'b0;
`endif
    end

    always_comb begin
        o_input_grant = '0;
        for (int mm = 0; mm < M; mm++) begin
            o_input_grant = o_input_grant | o_output_grant[mm];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_output_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_lock_arbiter
// Description : Scoreboard bench for output_lock_arbiter against a queue-based
//               reference model of the arbitration and credit rules.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_output_lock_arbiter;

    localparam int N       = 4;
    localparam int M       = 4;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    typedef struct packed {
        logic [0:M-1][0:N-1]  grant;
        logic [0:N-1]         igrant;
        logic [0:M-1]         locked;
        logic [0:M-1][CW-1:0] count;
        logic [0:M-1]         err;
    } exp_t;

    logic                 clk;
    logic                 reset;
    logic                 ce;
    logic [0:N-1]         i_valid;
    logic [0:N-1]         i_tail;
    logic [0:N-1][0:M-1]  i_output_req;
    logic [0:M-1]         i_credit_return;
    logic [0:M-1][0:N-1]  o_output_grant;
    logic [0:N-1]         o_input_grant;
    logic [0:M-1]         o_locked;
    logic [0:M-1][CW-1:0] o_credit_count;
    logic [0:M-1]         o_credit_err;

    output_lock_arbiter #(.N(N), .M(M), .CREDITS(CREDITS)) dut (
        .clk             (clk),
        .reset           (reset),
        .ce              (ce),
        .i_valid         (i_valid),
        .i_tail          (i_tail),
        .i_output_req    (i_output_req),
        .i_credit_return (i_credit_return),
        .o_output_grant  (o_output_grant),
        .o_input_grant   (o_input_grant),
        .o_locked        (o_locked),
        .o_credit_count  (o_credit_count),
        .o_credit_err    (o_credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: one record per output.
    bit m_locked[M];
    int m_owner[M];
    int m_ptr[M];
    int m_cred[M];
    bit m_err[M];

    task automatic model_reset();
        for (int m = 0; m < M; m++) begin
            m_locked[m] = 0;
            m_owner[m]  = 0;
            m_ptr[m]    = 0;
            m_cred[m]   = CREDITS;
            m_err[m]    = 0;
        end
    endtask

    function automatic bit eff_req(logic [0:N-1] v, logic [0:N-1][0:M-1] rq, int k, int m);
        return v[k] && rq[k][m] && ($countones(rq[k]) == 1);
    endfunction

    // Drive one cycle of stimulus, record the expected response, advance the model.
    task automatic apply(input logic rst, input logic ce_v, input logic [0:N-1] v,
                         input logic [0:N-1] t, input logic [0:N-1][0:M-1] rq,
                         input logic [0:M-1] cr);
        exp_t e;
        int   win[M];
        e = '0;
        for (int m = 0; m < M; m++) begin
            win[m] = -1;
            if (ce_v && m_cred[m] > 0) begin
                if (m_locked[m]) begin
                    if (eff_req(v, rq, m_owner[m], m)) win[m] = m_owner[m];
                end else begin
                    for (int off = 0; off < N; off++) begin
                        int k;
                        k = (m_ptr[m] + off) % N;
                        if (win[m] < 0 && eff_req(v, rq, k, m)) win[m] = k;
                    end
                end
            end
            if (win[m] >= 0) begin
                e.grant[m][win[m]] = 1'b1;
                e.igrant[win[m]]   = 1'b1;
            end
            e.locked[m] = m_locked[m];
            e.count[m]  = CW'(m_cred[m]);
            e.err[m]    = m_err[m];
        end
        exp_q.push_back(e);

        reset           = rst;
        ce              = ce_v;
        i_valid         = v;
        i_tail          = t;
        i_output_req    = rq;
        i_credit_return = cr;

        if (rst) begin
            model_reset();
        end else if (ce_v) begin
            for (int m = 0; m < M; m++) begin
                if (win[m] >= 0) begin
                    if (m_locked[m]) begin
                        if (t[win[m]]) m_locked[m] = 0;
                    end else begin
                        if (!t[win[m]]) begin
                            m_locked[m] = 1;
                            m_owner[m]  = win[m];
                        end
                        m_ptr[m] = (win[m] + 1) % N;
                    end
                end
                if (win[m] >= 0 && !cr[m]) begin
                    m_cred[m] = m_cred[m] - 1;
                end else if (win[m] < 0 && cr[m]) begin
                    if (m_cred[m] == CREDITS) begin
`ifdef OUTPUT_LOCK_CREDIT_CHECK_EN
                        m_err[m] = 1;
`endif
                    end else begin
                        m_cred[m] = m_cred[m] + 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic ce_v, input logic [0:N-1] v,
                        input logic [0:N-1] t, input logic [0:N-1][0:M-1] rq,
                        input logic [0:M-1] cr);
        @(posedge clk);
        #1;
        apply(rst, ce_v, v, t, rq, cr);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("output_grant", 64'(o_output_grant), 64'(e.grant));
                chk("input_grant",  64'(o_input_grant),  64'(e.igrant));
                chk("locked",       64'(o_locked),       64'(e.locked));
                chk("credit_count", 64'(o_credit_count), 64'(e.count));
                chk("credit_err",   64'(o_credit_err),   64'(e.err));
            end
        end
    end

    function automatic logic [0:M-1] onehot_out(int m);
        logic [0:M-1] r;
        r    = '0;
        r[m] = 1'b1;
        return r;
    endfunction

    initial begin
        logic [0:N-1][0:M-1] rq;
        logic [0:N-1]        v;
        logic [0:N-1]        t;
        logic [0:M-1]        cr;
        int                  wait_cyc;

        reset = 1'b1; ce = 1'b0; i_valid = '0; i_tail = '0;
        i_output_req = '0; i_credit_return = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // All inputs single-flit to output 2 until credits run out.
        for (int n = 0; n < N; n++) rq[n] = onehot_out(2);
        repeat (6) step(1'b0, 1'b1, '1, '1, rq, '0);
        // Credit return releases one more grant.
        step(1'b0, 1'b1, '1, '1, rq, 4'b0010);
        step(1'b0, 1'b1, '1, '1, rq, 4'b0000);
        step(1'b0, 1'b1, '1, '1, rq, 4'b0010);
        step(1'b1, 1'b1, '0, '0, '0, '0);

        // Three-flit packet from input 1 to output 0 against input 3.
        rq = '0; rq[1] = onehot_out(0); rq[3] = onehot_out(0);
        step(1'b0, 1'b1, 4'b0101, 4'b0001, rq, '0);
        step(1'b0, 1'b1, 4'b0101, 4'b0001, rq, '0);
        // Owner stalls; input 2 joins but must be ignored.
        rq[2] = onehot_out(0);
        step(1'b0, 1'b1, 4'b0011, 4'b0011, rq, '0);
        step(1'b0, 1'b1, 4'b0011, 4'b0011, rq, '0);
        step(1'b0, 1'b1, 4'b0111, 4'b0111, rq, '0);
        step(1'b0, 1'b1, 4'b0011, 4'b0011, rq, '0);

        // Lock output 3 by input 2, then reset mid-packet; 0/2 contest after.
        step(1'b1, 1'b1, '0, '0, '0, '0);
        rq = '0; rq[2] = onehot_out(3);
        step(1'b0, 1'b1, 4'b0010, 4'b0000, rq, '0);
        step(1'b0, 1'b1, 4'b0010, 4'b0000, rq, '0);
        step(1'b0, 1'b1, 4'b0010, 4'b0000, rq, '0);
        step(1'b1, 1'b1, 4'b0010, 4'b0000, rq, '0);
        rq[0] = onehot_out(3);
        step(1'b0, 1'b1, 4'b1010, 4'b1010, rq, '0);
        step(1'b0, 1'b1, 4'b1010, 4'b1010, rq, '0);

        // Return at full count: saturate (and flag when checking is built in).
        step(1'b0, 1'b1, '0, '0, '0, 4'b1000);
        step(1'b0, 1'b1, '0, '0, '0, 4'b1000);
        // ce low drops grants and returns.
        step(1'b0, 1'b0, 4'b1010, 4'b0000, rq, 4'b1111);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < N; n++) begin
                int sel;
                sel = $urandom_range(0, 15);
                if (sel < 2)      rq[n] = '0;
                else if (sel < 4) rq[n] = M'($urandom);
                else              rq[n] = onehot_out($urandom_range(0, M - 1));
                v[n] = ($urandom_range(0, 7) != 0);
                t[n] = ($urandom_range(0, 2) == 0);
            end
            for (int m = 0; m < M; m++) cr[m] = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), v, t, rq, cr);
        end

        @(posedge clk);
        #1;
        reset = 1'b0; ce = 1'b0;
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0 pending responses", exp_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
